// File: rtl/pipe_stage_hs.sv
// Parametrised pipeline stage register with valid/ready handshake, optional
// skid entry, masked flush (bubble insert or drop) and a saturating starve counter.
module pipe_stage_hs #(
  parameter int                DATA_W      = 64,
  parameter bit                SKID        = 1'b1,
  parameter bit                FLUSH_MODE  = 1'b1,
  parameter logic [DATA_W-1:0] KEEP_MASK   = 64'hFFFFFFFF_00000000,
  parameter logic [DATA_W-1:0] NOP_PAYLOAD = 64'h00000000_00000013,
  parameter logic [DATA_W-1:0] RST_PAYLOAD = 64'h00000004_00000013,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  starve_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              acc, snd;
  logic [DATA_W-1:0] bubble;

  assign out_valid  = (state_q != ST_EMPTY);
  assign out_data   = main_q;
  assign starve_cnt = cnt_q;

  // With a skid entry, ready is a flop so the upstream path is cut;
  // without it, ready passes out_ready straight through.
  assign in_ready = SKID ? ready_q : (!out_valid || out_ready);

  assign acc    = in_valid && in_ready;
  assign snd    = out_valid && out_ready;
  assign bubble = (in_data & KEEP_MASK) | (NOP_PAYLOAD & ~KEEP_MASK);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      skid_d = '0;
      if (FLUSH_MODE) begin
        state_d = ST_FULL;
        main_d  = bubble;
      end else begin
        state_d = ST_EMPTY;
      end
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          if (acc && snd) begin
            main_d = in_data;
          end else if (acc) begin
            if (SKID) begin
              state_d = ST_SKID;
              skid_d  = in_data;
            end
          end else if (snd) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (snd) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    ready_d = (state_d != ST_SKID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_PAYLOAD;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  // Starve counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_ready && !out_valid && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: three configurations share one stimulus stream and
// are checked every cycle against a FIFO-level model plus directed literals.
module tb_pipe_stage_hs;

  localparam int N = 3;
  localparam logic [63:0] RST_PL = 64'h00000004_00000013;
  localparam logic [63:0] NOP_PL = 64'h00000000_00000013;
  localparam logic [63:0] KEEP   = 64'hFFFFFFFF_00000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = '0;

  logic        ir [N];
  logic        ov [N];
  logic [63:0] od [N];
  logic [15:0] sc0, sc2;
  logic [3:0]  sc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0: defaults; u1: flush drops, 4-bit counter; u2: no skid entry
  pipe_stage_hs u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .starve_cnt(sc0));
  pipe_stage_hs #(.FLUSH_MODE(1'b0), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .starve_cnt(sc1));
  pipe_stage_hs #(.SKID(1'b0)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .starve_cnt(sc2));

  // Model: each stage is a FIFO of up to 2 (skid) or 1 entries
  logic [63:0] m_e [N][2];
  int          m_n [N];
  logic [63:0] m_show [N];
  int unsigned m_cnt [N];
  int unsigned m_lim [N] = '{65535, 15, 65535};
  bit          m_skid [N] = '{1'b1, 1'b1, 1'b0};
  bit          m_fm [N] = '{1'b1, 1'b0, 1'b1};
  bit          m_init = 1'b0;

  function automatic bit m_ready(int i);
    return m_skid[i] ? (m_n[i] < 2) : (m_n[i] == 0 || out_ready);
  endfunction

  task automatic m_step(int i);
    bit acc, snd;
    if (rst) begin
      m_n[i] = 0;
      m_show[i] = RST_PL;
      m_cnt[i] = 0;
      return;
    end
    acc = in_valid && m_ready(i);
    snd = (m_n[i] > 0) && out_ready;
    if (out_ready && m_n[i] == 0 && m_cnt[i] < m_lim[i]) m_cnt[i]++;
    if (flush) begin
      if (m_fm[i]) begin
        m_e[i][0] = (in_data & KEEP) | (NOP_PL & ~KEEP);
        m_n[i] = 1;
      end else begin
        m_n[i] = 0;
      end
    end else begin
      if (snd) begin
        m_e[i][0] = m_e[i][1];
        m_n[i]--;
      end
      if (acc) begin
        m_e[i][m_n[i]] = in_data;
        m_n[i]++;
      end
    end
    if (m_n[i] > 0) m_show[i] = m_e[i][0];
  endtask

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sc_of(int i);
    case (i)
      0: return {48'h0, sc0};
      1: return {60'h0, sc1};
      default: return {48'h0, sc2};
    endcase
  endfunction

  // Cycle-by-cycle comparison against the model
  always begin
    @(posedge clk);
    for (int i = 0; i < N; i++) m_step(i);
    if (rst) m_init = 1'b1;
    if (m_init) begin
      #1;
      for (int i = 0; i < N; i++) begin
        checkOutput($sformatf("u%0d.out_valid", i), {63'h0, ov[i]}, {63'h0, m_n[i] > 0});
        checkOutput($sformatf("u%0d.in_ready", i), {63'h0, ir[i]}, {63'h0, m_ready(i)});
        checkOutput($sformatf("u%0d.out_data", i), od[i], m_show[i]);
        checkOutput($sformatf("u%0d.starve_cnt", i), sc_of(i), 64'(m_cnt[i]));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic f, input logic v,
                               input logic [63:0] d, input logic o);
    @(negedge clk);
    rst = r;
    flush = f;
    in_valid = v;
    in_data = d;
    out_ready = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 64'h0, 0);
    applyStimulus(1, 0, 0, 64'h0, 0);
    checkOutput("reset.out_valid", {63'h0, ov[0]}, 64'h0);
    checkOutput("reset.out_data", od[0], 64'h00000004_00000013);
    checkOutput("reset.starve", sc_of(0), 64'h0);
    checkOutput("reset.in_ready", {63'h0, ir[0]}, 64'h1);

    // Stream 1,2,3
    applyStimulus(0, 0, 1, 64'h1, 1);
    checkOutput("stream.d1", od[0], 64'h1);
    applyStimulus(0, 0, 1, 64'h2, 1);
    checkOutput("stream.d2", od[0], 64'h2);
    applyStimulus(0, 0, 1, 64'h3, 1);
    checkOutput("stream.d3", od[0], 64'h3);
    applyStimulus(0, 0, 0, 64'h0, 1);
    checkOutput("stream.starve", sc_of(0), 64'h1);
    checkOutput("stream.drained", {63'h0, ov[0]}, 64'h0);

    // Backpressure into the skid entry
    applyStimulus(0, 0, 1, 64'hA, 0);
    applyStimulus(0, 0, 1, 64'hB, 0);
    checkOutput("bp.in_ready", {63'h0, ir[0]}, 64'h0);
    checkOutput("bp.headA", od[0], 64'hA);
    applyStimulus(0, 0, 1, 64'hC, 0);
    checkOutput("bp.stableA", od[0], 64'hA);
    applyStimulus(0, 0, 1, 64'hC, 1);
    checkOutput("bp.outB", od[0], 64'hB);
    applyStimulus(0, 0, 1, 64'hC, 1);
    checkOutput("bp.outC", od[0], 64'hC);
    applyStimulus(0, 0, 0, 64'h0, 1);
    checkOutput("bp.empty", {63'h0, ov[0]}, 64'h0);

    // Flush while holding two beats
    applyStimulus(0, 0, 1, 64'h11, 0);
    applyStimulus(0, 0, 1, 64'h22, 0);
    applyStimulus(0, 1, 1, 64'h00000008_DEADBEEF, 0);
    checkOutput("flush1.out_valid", {63'h0, ov[0]}, 64'h1);
    checkOutput("flush1.out_data", od[0], 64'h00000008_00000013);
    checkOutput("flush1.in_ready", {63'h0, ir[0]}, 64'h1);
    checkOutput("flush0.out_valid", {63'h0, ov[1]}, 64'h0);
    checkOutput("flush0.in_ready", {63'h0, ir[1]}, 64'h1);
    checkOutput("flush0.out_data", od[1], 64'h11);
    applyStimulus(0, 0, 0, 64'h0, 1);
    checkOutput("flush1.bubble_sent", {63'h0, ov[0]}, 64'h0);
    checkOutput("flush0.no_ab", {63'h0, ov[1]}, 64'h0);
    applyStimulus(0, 0, 0, 64'h0, 1);
    checkOutput("flush0.no_ab2", {63'h0, ov[1]}, 64'h0);

    // Flush with an in-flight accepted beat that must be discarded
    applyStimulus(0, 0, 1, 64'h33, 0);
    applyStimulus(0, 1, 1, 64'h12345678_9ABCDEF0, 1);
    checkOutput("flushacc.out_data", od[0], 64'h12345678_00000013);
    applyStimulus(0, 0, 0, 64'h0, 1);
    checkOutput("flushacc.empty", {63'h0, ov[0]}, 64'h0);

    // Reset while in the skid state, then saturate the short counter
    applyStimulus(0, 0, 1, 64'h55, 0);
    applyStimulus(0, 0, 1, 64'h66, 0);
    applyStimulus(1, 0, 0, 64'h0, 1);
    checkOutput("rstskid.out_valid", {63'h0, ov[0]}, 64'h0);
    checkOutput("rstskid.out_data", od[0], 64'h00000004_00000013);
    checkOutput("rstskid.starve", sc_of(0), 64'h0);
    for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0, 64'h0, 1);
    checkOutput("sat.u0", sc_of(0), 64'd20);
    checkOutput("sat.u1", sc_of(1), 64'd15);

    // Mixed traffic against the model
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                    1'($urandom_range(1)), {$urandom, $urandom}, 1'($urandom_range(1)));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
